// File: rtl/trace_pkg.sv
// Shared types for the retirement trace transmitter.
// - trace_kind_e : instruction class reported with each record.
// - trace_rec_t  : one retire record as stored in the FIFO and shown on the stream.
// - iss_t        : issue-stage shadow (no decode yet).
// - shadow_t     : EX/MEM/WB shadow, carrying the decode sampled at issue.
package trace_pkg;

  typedef enum logic [1:0] {
    KIND_OTHER = 2'b00,
    KIND_R     = 2'b01,
    KIND_I     = 2'b10,
    KIND_J     = 2'b11
  } trace_kind_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    trace_kind_e kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] seq;
  } trace_rec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } iss_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    trace_kind_e kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } shadow_t;

  // One-hot (or all-zero) decode to the 2-bit kind: {j|i, j|r}.
  function automatic trace_kind_e decode_kind(input logic is_r, input logic is_i,
                                              input logic is_j);
    return trace_kind_e'({is_j | is_i, is_j | is_r});
  endfunction

endpackage

// File: rtl/retire_trace_tx_if.sv
// Retire-trace stream bundle.
// Handshake: the master raises trace_valid with a stable record and keeps both
// unchanged until a cycle where trace_ready is also high; that cycle transfers
// the record. trace_valid never depends combinationally on trace_ready.
// - master : transmitter side (drives valid + record, samples ready).
// - slave  : consumer side.
interface retire_trace_tx_if;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;
  logic [1:0]  trace_kind;
  logic [4:0]  trace_rs;
  logic [4:0]  trace_rt;
  logic [4:0]  trace_rd;
  logic        trace_wr_en;
  logic [4:0]  trace_wr_addr;
  logic [31:0] trace_wr_data;
  logic [31:0] trace_seq;

  modport master (
    output trace_valid, trace_pc, trace_instr, trace_kind, trace_rs, trace_rt,
           trace_rd, trace_wr_en, trace_wr_addr, trace_wr_data, trace_seq,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_pc, trace_instr, trace_kind, trace_rs, trace_rt,
           trace_rd, trace_wr_en, trace_wr_addr, trace_wr_data, trace_seq,
    output trace_ready
  );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO of retire records.
// Ports: clk, reset (sync, active-low; also clears storage), push_i/push_data_i,
// pop_i, full_o, empty_o, head_o (oldest entry, read straight from flops).
// A push while full is accepted only when a pop happens in the same cycle.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  trace_rec_t push_data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output trace_rec_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  trace_rec_t  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/retire_trace_tx.sv
// Retirement trace transmitter: shadows fetched instructions through ISS, EX,
// MEM and WB, forms one record per retirement, queues it and streams it out.
// Ports: clk, reset (sync, active-low); fetch_valid/pc_fetch/instr_fetch;
// is_{r,i,j}_type_iss and rs/rt/rd_iss (issue decode); pipe_stall; flush_iss;
// reg_wr_wb/wr_addr_wb/wr_data_wb (write-back); trace (record stream, master);
// drop_cnt (saturating count of records lost on a full FIFO).
module retire_trace_tx
  import trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [31:0]       pc_fetch,
  input  logic [31:0]       instr_fetch,
  input  logic              is_r_type_iss,
  input  logic              is_i_type_iss,
  input  logic              is_j_type_iss,
  input  logic [4:0]        rs_iss,
  input  logic [4:0]        rt_iss,
  input  logic [4:0]        rd_iss,
  input  logic              pipe_stall,
  input  logic              flush_iss,
  input  logic              reg_wr_wb,
  input  logic [4:0]        wr_addr_wb,
  input  logic [31:0]       wr_data_wb,
  retire_trace_tx_if.master trace,
  output logic [CNT_W-1:0]  drop_cnt
);

  iss_t       iss_q, iss_d;
  shadow_t    ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [31:0]      seq_q, seq_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  trace_rec_t rec;
  trace_rec_t head;
  logic       retire;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       push;
  logic       drop;

  // Shadow pipeline advance; a stall freezes everything, including the flush.
  always_comb begin
    iss_d = iss_q;
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!pipe_stall) begin
      iss_d.valid = fetch_valid & ~flush_iss;
      iss_d.pc    = pc_fetch;
      iss_d.instr = instr_fetch;
      ex_d.valid  = iss_q.valid & ~flush_iss;
      ex_d.pc     = iss_q.pc;
      ex_d.instr  = iss_q.instr;
      ex_d.kind   = decode_kind(is_r_type_iss, is_i_type_iss, is_j_type_iss);
      ex_d.rs     = rs_iss;
      ex_d.rt     = rt_iss;
      ex_d.rd     = rd_iss;
      mem_d       = ex_q;
      wb_d        = mem_q;
    end
  end

  assign retire = wb_q.valid & ~pipe_stall;
  // The pop is decided from registered FIFO state, so ready never feeds valid.
  assign pop    = ~fifo_empty & trace.trace_ready;
  assign push   = retire & (~fifo_full | pop);
  assign drop   = retire & fifo_full & ~pop;

  always_comb begin
    rec         = '0;
    rec.pc      = wb_q.pc;
    rec.instr   = wb_q.instr;
    rec.kind    = wb_q.kind;
    rec.rs      = wb_q.rs;
    rec.rt      = wb_q.rt;
    rec.rd      = wb_q.rd;
    rec.wr_en   = reg_wr_wb & (wr_addr_wb != 5'd0);
    rec.wr_addr = wr_addr_wb;
    rec.wr_data = wr_data_wb;
    rec.seq     = seq_q;
  end

  // Sequence advances on every retirement, kept or dropped, so gaps are visible.
  always_comb begin
    seq_d  = retire ? seq_q + 32'd1 : seq_q;
    drop_d = (drop && !(&drop_q)) ? drop_q + CNT_W'(1) : drop_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      iss_q  <= '0;
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      seq_q  <= '0;
      drop_q <= '0;
    end else begin
      iss_q  <= iss_d;
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      seq_q  <= seq_d;
      drop_q <= drop_d;
    end
  end

  trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (rec),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  assign trace.trace_valid   = ~fifo_empty;
  assign trace.trace_pc      = head.pc;
  assign trace.trace_instr   = head.instr;
  assign trace.trace_kind    = head.kind;
  assign trace.trace_rs      = head.rs;
  assign trace.trace_rt      = head.rt;
  assign trace.trace_rd      = head.rd;
  assign trace.trace_wr_en   = head.wr_en;
  assign trace.trace_wr_addr = head.wr_addr;
  assign trace.trace_wr_data = head.wr_data;
  assign trace.trace_seq     = head.seq;
  assign drop_cnt            = drop_q;

endmodule

// File: tb/tb_retire_trace_tx.sv
// Directed bench for retire_trace_tx (FIFO_DEPTH=8, CNT_W=16).
module tb_retire_trace_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] pc_fetch;
  logic [31:0] instr_fetch;
  logic        is_r_type_iss, is_i_type_iss, is_j_type_iss;
  logic [4:0]  rs_iss, rt_iss, rd_iss;
  logic        pipe_stall;
  logic        flush_iss;
  logic        reg_wr_wb;
  logic [4:0]  wr_addr_wb;
  logic [31:0] wr_data_wb;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  retire_trace_tx_if trace_if ();

  retire_trace_tx #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_valid   (fetch_valid),
    .pc_fetch      (pc_fetch),
    .instr_fetch   (instr_fetch),
    .is_r_type_iss (is_r_type_iss),
    .is_i_type_iss (is_i_type_iss),
    .is_j_type_iss (is_j_type_iss),
    .rs_iss        (rs_iss),
    .rt_iss        (rt_iss),
    .rd_iss        (rd_iss),
    .pipe_stall    (pipe_stall),
    .flush_iss     (flush_iss),
    .reg_wr_wb     (reg_wr_wb),
    .wr_addr_wb    (wr_addr_wb),
    .wr_data_wb    (wr_data_wb),
    .trace         (trace_if),
    .drop_cnt      (drop_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    fetch_valid = 1'b0;
    flush_iss   = 1'b0;
    pipe_stall  = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic set_iss(input logic r, input logic i, input logic j,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
    is_r_type_iss = r;
    is_i_type_iss = i;
    is_j_type_iss = j;
    rs_iss = rs;
    rt_iss = rt;
    rd_iss = rd;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    reg_wr_wb  = en;
    wr_addr_wb = addr;
    wr_data_wb = data;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    fetch_valid = 1'b1;
    pc_fetch    = pc;
    instr_fetch = instr;
    tick();
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input logic [31:0] pc, input logic [31:0] seq);
    check({tag, "_valid"}, {31'd0, trace_if.trace_valid}, 32'd1);
    check({tag, "_pc"}, trace_if.trace_pc, pc);
    check({tag, "_seq"}, trace_if.trace_seq, seq);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    trace_if.trace_ready = 1'b1;
    pc_fetch = '0;
    instr_fetch = '0;
    set_iss(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    reset = 1'b0;
    fetch_valid = 1'b0;
    flush_iss = 1'b0;
    pipe_stall = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'd0, trace_if.trace_valid}, 32'd0);
    check("rst_pc", trace_if.trace_pc, 32'd0);
    check("rst_seq", trace_if.trace_seq, 32'd0);
    check("rst_wr_data", trace_if.trace_wr_data, 32'd0);
    check("rst_drop", {16'd0, drop_cnt}, 32'd0);
    reset = 1'b1;

    // single addi $2,$0,10: record appears after edge N+4
    set_iss(1'b0, 1'b1, 1'b0, 5'd0, 5'd2, 5'd0);
    set_wb(1'b1, 5'd2, 32'h0000_000a);
    fetch(32'h0, 32'h2002_000a);          // edge N
    fetch_valid = 1'b0;
    tick(); tick(); tick();               // N+1..N+3
    check("t1_early_valid", {31'd0, trace_if.trace_valid}, 32'd0);
    tick();                               // N+4
    check_rec("t1", 32'h0, 32'd0);
    check("t1_instr", trace_if.trace_instr, 32'h2002_000a);
    check("t1_kind", {30'd0, trace_if.trace_kind}, 32'd2);
    check("t1_rt", {27'd0, trace_if.trace_rt}, 32'd2);
    check("t1_wr_en", {31'd0, trace_if.trace_wr_en}, 32'd1);
    check("t1_wr_addr", {27'd0, trace_if.trace_wr_addr}, 32'd2);
    check("t1_wr_data", trace_if.trace_wr_data, 32'h0000_000a);
    tick();
    check("t1_popped", {31'd0, trace_if.trace_valid}, 32'd0);

    // four back-to-back R-type instructions
    do_reset();
    set_iss(1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 5'd5);
    set_wb(1'b1, 5'd5, 32'h1234);
    for (int k = 0; k < 4; k++) fetch(32'(k * 4), 32'h0085_2820);
    fetch_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_rec("b2b", 32'(k * 4), 32'(k));
    end
    check("b2b_kind", {30'd0, trace_if.trace_kind}, 32'd1);
    check("b2b_rd", {27'd0, trace_if.trace_rd}, 32'd5);
    tick();
    check("b2b_end", {31'd0, trace_if.trace_valid}, 32'd0);

    // flush squashes pc 0x8 (ISS) and 0xc (fetch)
    do_reset();
    set_iss(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    fetch(32'h0, 32'h1);
    fetch(32'h4, 32'h2);
    fetch(32'h8, 32'h3);
    flush_iss = 1'b1;
    fetch(32'hc, 32'h4);
    flush_iss = 1'b0;
    fetch(32'h10, 32'h5);
    check_rec("fl0", 32'h0, 32'd0);
    check("fl_kind", {30'd0, trace_if.trace_kind}, 32'd3);
    fetch_valid = 1'b0;
    tick();
    check_rec("fl1", 32'h4, 32'd1);
    tick();
    check("fl_gap1", {31'd0, trace_if.trace_valid}, 32'd0);
    tick();
    check("fl_gap2", {31'd0, trace_if.trace_valid}, 32'd0);
    tick();
    check_rec("fl2", 32'h10, 32'd2);
    tick();
    check("fl_end", {31'd0, trace_if.trace_valid}, 32'd0);

    // three-cycle stall delays both records by three cycles
    do_reset();
    set_iss(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    fetch(32'h0, 32'h1);
    fetch(32'h4, 32'h2);
    fetch_valid = 1'b0;
    tick();
    pipe_stall = 1'b1;
    tick(); tick(); tick();
    pipe_stall = 1'b0;
    tick();
    check("st_early", {31'd0, trace_if.trace_valid}, 32'd0);
    tick();
    check_rec("st0", 32'h0, 32'd0);
    check("st_kind", {30'd0, trace_if.trace_kind}, 32'd0);
    tick();
    check_rec("st1", 32'h4, 32'd1);
    tick();
    check("st_end", {31'd0, trace_if.trace_valid}, 32'd0);

    // backpressure: 11 retirements, 8 queued, 2 dropped, 11th pushed with pop
    do_reset();
    trace_if.trace_ready = 1'b0;
    set_wb(1'b1, 5'd7, 32'h77);
    for (int k = 0; k < 11; k++) fetch(32'(k * 4), 32'(k));
    fetch_valid = 1'b0;
    tick();                                // 8 queued, none dropped yet
    check("bp_drop0", {16'd0, drop_cnt}, 32'd0);
    tick(); tick();                        // two drops
    check("bp_drop2", {16'd0, drop_cnt}, 32'd2);
    check_rec("bp_head", 32'h0, 32'd0);
    trace_if.trace_ready = 1'b1;
    tick();                                // pop seq0, push seq10 while full
    check("bp_drop_keep", {16'd0, drop_cnt}, 32'd2);
    check_rec("bp_d1", 32'h4, 32'd1);
    for (int k = 2; k < 8; k++) begin
      tick();
      check_rec("bp_d", 32'(k * 4), 32'(k));
    end
    tick();
    check_rec("bp_last", 32'h28, 32'd10);
    tick();
    check("bp_empty", {31'd0, trace_if.trace_valid}, 32'd0);

    // write to r0 is reported without a write enable
    do_reset();
    set_iss(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    set_wb(1'b1, 5'd0, 32'h55);
    fetch(32'h40, 32'h2000_0055);
    fetch_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check_rec("r0", 32'h40, 32'd0);
    check("r0_wr_en", {31'd0, trace_if.trace_wr_en}, 32'd0);
    check("r0_wr_data", trace_if.trace_wr_data, 32'h55);

    // reset with three records queued
    do_reset();
    trace_if.trace_ready = 1'b0;
    set_wb(1'b1, 5'd9, 32'h99);
    fetch(32'h60, 32'h1);
    fetch(32'h64, 32'h2);
    fetch(32'h68, 32'h3);
    fetch_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check_rec("mr_q", 32'h60, 32'd0);
    reset = 1'b0;
    tick();
    check("mr_valid", {31'd0, trace_if.trace_valid}, 32'd0);
    check("mr_pc", trace_if.trace_pc, 32'd0);
    reset = 1'b1;
    trace_if.trace_ready = 1'b1;
    fetch(32'h80, 32'h4);
    fetch_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check_rec("mr_new", 32'h80, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
